// File: rtl/reorder_buffer_pkg.sv
// ----------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared types for the Tomasulo reorder buffer slice.
//   lc3b_opcode : LC-3b opcode encoding carried through the ROB
//   lc3b_reg    : architectural register index (or branch nzp for op_br)
//   rob_entry_t : one ROB entry {valid, ready, opcode, dest, predict, value}
//   ROB_DEPTH   : number of entries, 2**TAG_WIDTH
// Optional feature macro used by the ROB: ROB_BYPASS_EN (see reorder_buffer.sv).
// ----------------------------------------------------------------------------
package reorder_buffer_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int TAG_WIDTH  = 3;
    localparam int ROB_DEPTH  = 2 ** TAG_WIDTH;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef logic [2:0] lc3b_reg;

    // The value field is fixed at DATA_WIDTH; the ROB's data_width parameter
    // must stay equal to it.
    typedef struct packed {
        logic                  valid;
        logic                  ready;
        lc3b_opcode            opcode;
        lc3b_reg               dest;
        logic                  predict;
        logic [DATA_WIDTH-1:0] value;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// ----------------------------------------------------------------------------
// reorder_buffer_if
// Bundles every ROB-facing signal of the issue stage, CDB, operand lookup and
// commit controller.
//   slave  : seen by the ROB (issue/CDB/lookup/commit requests in, status out)
//   master : seen by the issue/CDB/commit side
// Ports: WE, opcode_in, dest_in, predict_in, alloc_tag, full (issue);
//        cdb_valid, cdb_tag, cdb_value (CDB); srX_tag/value/ready (lookup);
//        valid_out, opcode_out, dest_out, value_out, predict_out, empty, RE,
//        flush (commit).
// ----------------------------------------------------------------------------
import reorder_buffer_pkg::*;

interface reorder_buffer_if #(
    parameter int data_width = DATA_WIDTH,
    parameter int tag_width  = TAG_WIDTH
);
    logic                  WE;
    lc3b_opcode            opcode_in;
    lc3b_reg               dest_in;
    logic                  predict_in;
    logic [tag_width-1:0]  alloc_tag;
    logic                  full;

    logic                  cdb_valid;
    logic [tag_width-1:0]  cdb_tag;
    logic [data_width-1:0] cdb_value;

    logic [tag_width-1:0]  sr1_tag;
    logic [tag_width-1:0]  sr2_tag;
    logic [data_width-1:0] sr1_value;
    logic [data_width-1:0] sr2_value;
    logic                  sr1_ready;
    logic                  sr2_ready;

    logic                  valid_out;
    lc3b_opcode            opcode_out;
    lc3b_reg               dest_out;
    logic [data_width-1:0] value_out;
    logic                  predict_out;
    logic                  empty;
    logic                  RE;
    logic                  flush;

    modport slave (
        input  WE, opcode_in, dest_in, predict_in,
        input  cdb_valid, cdb_tag, cdb_value,
        input  sr1_tag, sr2_tag,
        input  RE, flush,
        output alloc_tag, full,
        output sr1_value, sr2_value, sr1_ready, sr2_ready,
        output valid_out, opcode_out, dest_out, value_out, predict_out, empty
    );

    modport master (
        output WE, opcode_in, dest_in, predict_in,
        output cdb_valid, cdb_tag, cdb_value,
        output sr1_tag, sr2_tag,
        output RE, flush,
        input  alloc_tag, full,
        input  sr1_value, sr2_value, sr1_ready, sr2_ready,
        input  valid_out, opcode_out, dest_out, value_out, predict_out, empty
    );

endinterface

// File: rtl/reorder_buffer_rob_ptr.sv
// ----------------------------------------------------------------------------
// reorder_buffer_rob_ptr
// Wrap-around pointer register used for the ROB head and tail.
//   clk, reset : clock, asynchronous active-high reset (pointer -> 0)
//   clear      : synchronous clear, wins over inc
//   inc        : advance by one, wrapping modulo 2**tag_width
//   ptr        : current pointer value
// ----------------------------------------------------------------------------
module reorder_buffer_rob_ptr #(
    parameter int tag_width = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc,
    output logic [tag_width-1:0] ptr
);

    // Natural binary overflow gives the 7 -> 0 wrap with no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// ----------------------------------------------------------------------------
// reorder_buffer
// Circular in-order reorder buffer for the Tomasulo datapath. Issue allocates
// at the tail, the CDB fills entries by tag, commit drains the head through a
// valid_out / RE handshake, and two lookup ports serve operand reads.
//   clk, reset : clock, asynchronous active-high reset
//   rob        : reorder_buffer_if.slave (issue, CDB, lookup, commit, flush)
// Optional feature: define ROB_BYPASS_EN to forward a same-cycle CDB
// broadcast onto the lookup ports. Without it lookups see registered state.
// ----------------------------------------------------------------------------
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int tag_width  = TAG_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    reorder_buffer_if.slave rob
);

    localparam int depth = 2 ** tag_width;
    localparam logic [tag_width:0] depth_count = (tag_width + 1)'(depth);

    rob_entry_t           entries [depth];
    logic [tag_width-1:0] head;
    logic [tag_width-1:0] tail;
    logic [tag_width:0]   count;
    logic                 alloc_ok;
    logic                 retire_ok;
    logic                 cdb_hit;

    assign rob.full      = (count == depth_count);
    assign rob.empty     = (count == '0);
    assign rob.alloc_tag = tail;

    assign rob.valid_out   = !rob.empty && entries[head].ready;
    assign rob.opcode_out  = entries[head].opcode;
    assign rob.dest_out    = entries[head].dest;
    assign rob.value_out   = entries[head].value;
    assign rob.predict_out = entries[head].predict;

    assign alloc_ok  = rob.WE && !rob.full;
    assign retire_ok = rob.RE && rob.valid_out;

    // A broadcast aimed at the entry retiring this edge is dropped so the
    // retire and the write never race on the same slot.
    assign cdb_hit = rob.cdb_valid && entries[rob.cdb_tag].valid &&
                     !(retire_ok && (rob.cdb_tag == head));

    reorder_buffer_rob_ptr #(.tag_width(tag_width)) u_head (
        .clk   (clk),
        .reset (reset),
        .clear (rob.flush),
        .inc   (retire_ok),
        .ptr   (head)
    );

    reorder_buffer_rob_ptr #(.tag_width(tag_width)) u_tail (
        .clk   (clk),
        .reset (reset),
        .clear (rob.flush),
        .inc   (alloc_ok),
        .ptr   (tail)
    );

    // Allocate and retire together leave the occupancy unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (rob.flush) begin
            count <= '0;
        end else if (alloc_ok && !retire_ok) begin
            count <= count + 1'b1;
        end else if (retire_ok && !alloc_ok) begin
            count <= count - 1'b1;
        end
    end

    // Allocation writes the tail slot, which is never the head slot being
    // retired and never a valid slot a CDB write could target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) begin
                entries[i] <= '0;
            end
        end else if (rob.flush) begin
            for (int i = 0; i < depth; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].ready <= 1'b0;
            end
        end else begin
            if (cdb_hit) begin
                entries[rob.cdb_tag].value <= rob.cdb_value;
                entries[rob.cdb_tag].ready <= 1'b1;
            end
            if (retire_ok) begin
                entries[head].valid <= 1'b0;
                entries[head].ready <= 1'b0;
            end
            if (alloc_ok) begin
                entries[tail] <= '{valid:   1'b1,
                                   ready:   1'b0,
                                   opcode:  rob.opcode_in,
                                   dest:    rob.dest_in,
                                   predict: rob.predict_in,
                                   value:   '0};
            end
        end
    end

    always_comb begin
        rob.sr1_value = entries[rob.sr1_tag].value;
        rob.sr1_ready = entries[rob.sr1_tag].valid && entries[rob.sr1_tag].ready;
        rob.sr2_value = entries[rob.sr2_tag].value;
        rob.sr2_ready = entries[rob.sr2_tag].valid && entries[rob.sr2_tag].ready;
`ifdef ROB_BYPASS_EN
        if (rob.cdb_valid && (rob.cdb_tag == rob.sr1_tag) && entries[rob.sr1_tag].valid) begin
            rob.sr1_value = rob.cdb_value;
            rob.sr1_ready = 1'b1;
        end
        if (rob.cdb_valid && (rob.cdb_tag == rob.sr2_tag) && entries[rob.sr2_tag].valid) begin
            rob.sr2_value = rob.cdb_value;
            rob.sr2_ready = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// ----------------------------------------------------------------------------
// tb_reorder_buffer
// Self-checking bench for reorder_buffer. A table of per-cycle vectors holds
// the inputs and the expected empty/full/valid_out/alloc_tag after the edge;
// a queue of in-flight instructions supplies the expected head fields at each
// retire. Hand-written sequences cover lookups, post-flush state and a reset
// asserted mid-cycle. Honours ROB_BYPASS_EN for the lookup expectations.
// ----------------------------------------------------------------------------
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    reorder_buffer_if rob_bus ();

    reorder_buffer dut (
        .clk   (clk),
        .reset (reset),
        .rob   (rob_bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       we;
        lc3b_opcode op;
        logic [2:0] dest;
        logic       pred;
        logic       cv;
        logic [2:0] ct;
        logic [15:0] cval;
        logic       re;
        logic       fl;
        logic       e_empty;
        logic       e_full;
        logic       e_vout;
        logic [2:0] e_tag;
    } vec_t;

    typedef struct {
        logic [2:0]  tag;
        lc3b_opcode  op;
        logic [2:0]  dest;
        logic        pred;
        logic [15:0] value;
        logic        ready;
    } sb_t;

    vec_t       vecs[$];
    sb_t        sb[$];
    logic [2:0] model_tail = 3'd0;

    function automatic vec_t mk(input logic we, input lc3b_opcode op, input logic [2:0] dest,
                                input logic pred, input logic cv, input logic [2:0] ct,
                                input logic [15:0] cval, input logic re, input logic fl,
                                input logic e_empty, input logic e_full, input logic e_vout,
                                input logic [2:0] e_tag);
        vec_t v;
        v.we = we; v.op = op; v.dest = dest; v.pred = pred;
        v.cv = cv; v.ct = ct; v.cval = cval; v.re = re; v.fl = fl;
        v.e_empty = e_empty; v.e_full = e_full; v.e_vout = e_vout; v.e_tag = e_tag;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic driveIdle();
        rob_bus.WE         = 1'b0;
        rob_bus.opcode_in  = op_add;
        rob_bus.dest_in    = 3'd0;
        rob_bus.predict_in = 1'b0;
        rob_bus.cdb_valid  = 1'b0;
        rob_bus.cdb_tag    = 3'd0;
        rob_bus.cdb_value  = 16'h0;
        rob_bus.RE         = 1'b0;
        rob_bus.flush      = 1'b0;
    endtask

    // Drives one cycle of a vector, updates the in-flight queue from the
    // pre-edge view, and checks the status outputs at the following negedge.
    task automatic applyStimulus(input vec_t v, input int idx);
        int pre_size;
        rob_bus.WE         = v.we;
        rob_bus.opcode_in  = v.op;
        rob_bus.dest_in    = v.dest;
        rob_bus.predict_in = v.pred;
        rob_bus.cdb_valid  = v.cv;
        rob_bus.cdb_tag    = v.ct;
        rob_bus.cdb_value  = v.cval;
        rob_bus.RE         = v.re;
        rob_bus.flush      = v.fl;
        #1;
        if (v.fl) begin
            sb.delete();
            model_tail = 3'd0;
        end else begin
            pre_size = sb.size();
            if (v.re && sb.size() > 0 && sb[0].ready) begin
                checkOutput($sformatf("commit_opcode[%0d]", idx), 32'(rob_bus.opcode_out), 32'(sb[0].op));
                checkOutput($sformatf("commit_dest[%0d]", idx), 32'(rob_bus.dest_out), 32'(sb[0].dest));
                checkOutput($sformatf("commit_value[%0d]", idx), 32'(rob_bus.value_out), 32'(sb[0].value));
                checkOutput($sformatf("commit_predict[%0d]", idx), 32'(rob_bus.predict_out), 32'(sb[0].pred));
                void'(sb.pop_front());
            end
            if (v.cv) begin
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].tag == v.ct) begin
                        sb[i].value = v.cval;
                        sb[i].ready = 1'b1;
                    end
                end
            end
            if (v.we && pre_size < ROB_DEPTH) begin
                sb.push_back('{model_tail, v.op, v.dest, v.pred, 16'h0, 1'b0});
                model_tail = model_tail + 3'd1;
            end
        end
        @(posedge clk);
        #1;
        driveIdle();
        @(negedge clk);
        checkOutput($sformatf("empty[%0d]", idx), 32'(rob_bus.empty), 32'(v.e_empty));
        checkOutput($sformatf("full[%0d]", idx), 32'(rob_bus.full), 32'(v.e_full));
        checkOutput($sformatf("valid_out[%0d]", idx), 32'(rob_bus.valid_out), 32'(v.e_vout));
        checkOutput($sformatf("alloc_tag[%0d]", idx), 32'(rob_bus.alloc_tag), 32'(v.e_tag));
    endtask

    initial begin
        driveIdle();
        rob_bus.sr1_tag = 3'd0;
        rob_bus.sr2_tag = 3'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_empty", 32'(rob_bus.empty), 32'd1);
        checkOutput("reset_full", 32'(rob_bus.full), 32'd0);
        checkOutput("reset_valid_out", 32'(rob_bus.valid_out), 32'd0);
        checkOutput("reset_alloc_tag", 32'(rob_bus.alloc_tag), 32'd0);
        checkOutput("reset_value_out", 32'(rob_bus.value_out), 32'd0);
        checkOutput("reset_opcode_out", 32'(rob_bus.opcode_out), 32'd0);
        checkOutput("reset_dest_out", 32'(rob_bus.dest_out), 32'd0);

        //              we op      dst   p  cv ct   cval      re fl  emp ful vo tag
        // basic allocate / complete / retire
        vecs.push_back(mk(1, op_add, 3'd3, 0, 0, 3'd0, 16'h0000, 0, 0,  0, 0, 0, 3'd1));
        vecs.push_back(mk(0, op_add, 3'd0, 0, 1, 3'd0, 16'h0005, 0, 0,  0, 0, 1, 3'd1));
        vecs.push_back(mk(0, op_add, 3'd0, 0, 0, 3'd0, 16'h0000, 1, 0,  1, 0, 0, 3'd1));
        vecs.push_back(mk(0, op_add, 3'd0, 0, 0, 3'd0, 16'h0000, 0, 1,  1, 0, 0, 3'd0));
        // fill all 8 entries, tail wraps back to 0
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1, lc3b_opcode'(4'(i + 1)), 3'(i), 1'(i), 0, 3'd0, 16'h0, 0, 0,
                              0, (i == 7), 0, 3'(i + 1)));
        end
        vecs.push_back(mk(1, op_trap, 3'd7, 1, 0, 3'd0, 16'h0000, 0, 0,  0, 1, 0, 3'd0));
        vecs.push_back(mk(0, op_add, 3'd0, 0, 1, 3'd0, 16'h00A0, 0, 0,  0, 1, 1, 3'd0));
        vecs.push_back(mk(1, op_trap, 3'd7, 1, 0, 3'd0, 16'h0000, 1, 0,  0, 0, 0, 3'd0));
        vecs.push_back(mk(1, op_not, 3'd5, 0, 1, 3'd1, 16'h00B1, 0, 0,  0, 1, 1, 3'd1));
        vecs.push_back(mk(1, op_trap, 3'd6, 1, 0, 3'd0, 16'h0000, 1, 0,  0, 0, 0, 3'd1));
        vecs.push_back(mk(1, op_shf, 3'd4, 0, 1, 3'd2, 16'h00C2, 0, 0,  0, 1, 1, 3'd2));
        vecs.push_back(mk(1, op_sti, 3'd1, 0, 1, 3'd3, 16'hDEAD, 1, 1,  1, 0, 0, 3'd0));
        // out-of-order completion, in-order retire
        vecs.push_back(mk(1, op_ldr, 3'd1, 0, 0, 3'd0, 16'h0000, 0, 0,  0, 0, 0, 3'd1));
        vecs.push_back(mk(1, op_str, 3'd2, 0, 0, 3'd0, 16'h0000, 0, 0,  0, 0, 0, 3'd2));
        vecs.push_back(mk(1, op_br,  3'd2, 1, 0, 3'd0, 16'h0000, 0, 0,  0, 0, 0, 3'd3));
        vecs.push_back(mk(0, op_add, 3'd0, 0, 1, 3'd2, 16'h0222, 0, 0,  0, 0, 0, 3'd3));
        vecs.push_back(mk(0, op_add, 3'd0, 0, 1, 3'd1, 16'h0111, 0, 0,  0, 0, 0, 3'd3));
        vecs.push_back(mk(0, op_add, 3'd0, 0, 0, 3'd0, 16'h0000, 1, 0,  0, 0, 0, 3'd3));
        vecs.push_back(mk(0, op_add, 3'd0, 0, 1, 3'd0, 16'h0100, 0, 0,  0, 0, 1, 3'd3));
        vecs.push_back(mk(0, op_add, 3'd0, 0, 0, 3'd0, 16'h0000, 1, 0,  0, 0, 1, 3'd3));
        vecs.push_back(mk(1, op_lea, 3'd6, 0, 0, 3'd0, 16'h0000, 1, 0,  0, 0, 1, 3'd4));
        vecs.push_back(mk(0, op_add, 3'd0, 0, 0, 3'd0, 16'h0000, 1, 0,  0, 0, 0, 3'd4));
        vecs.push_back(mk(0, op_add, 3'd0, 0, 1, 3'd3, 16'h0333, 0, 0,  0, 0, 1, 3'd4));
        vecs.push_back(mk(0, op_add, 3'd0, 0, 0, 3'd0, 16'h0000, 1, 0,  1, 0, 0, 3'd4));
        vecs.push_back(mk(1, op_jmp, 3'd7, 0, 0, 3'd0, 16'h0000, 1, 0,  0, 0, 0, 3'd5));
        // five occupied, then flush with simultaneous CDB, WE and RE
        vecs.push_back(mk(1, op_and, 3'd1, 0, 0, 3'd0, 16'h0000, 0, 0,  0, 0, 0, 3'd6));
        vecs.push_back(mk(1, op_and, 3'd2, 0, 0, 3'd0, 16'h0000, 0, 0,  0, 0, 0, 3'd7));
        vecs.push_back(mk(1, op_and, 3'd3, 0, 0, 3'd0, 16'h0000, 0, 0,  0, 0, 0, 3'd0));
        vecs.push_back(mk(1, op_and, 3'd4, 0, 0, 3'd0, 16'h0000, 0, 0,  0, 0, 0, 3'd1));
        vecs.push_back(mk(1, op_jsr, 3'd5, 1, 1, 3'd4, 16'h0444, 1, 1,  1, 0, 0, 3'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // after flush no entry may report ready
        for (int t = 0; t < 8; t++) begin
            rob_bus.sr1_tag = 3'(t);
            rob_bus.sr2_tag = 3'(7 - t);
            #1;
            checkOutput($sformatf("flushed_sr1_ready[%0d]", t), 32'(rob_bus.sr1_ready), 32'd0);
            checkOutput($sformatf("flushed_sr2_ready[%0d]", 7 - t), 32'(rob_bus.sr2_ready), 32'd0);
        end
        @(negedge clk);

        // operand lookup
        applyStimulus(mk(1, op_add, 3'd1, 0, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 0, 3'd1), 100);
        applyStimulus(mk(1, op_and, 3'd2, 0, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 0, 3'd2), 101);
        applyStimulus(mk(0, op_add, 3'd0, 0, 1, 3'd1, 16'h1234, 0, 0, 0, 0, 0, 3'd2), 102);
        rob_bus.sr1_tag = 3'd1;
        rob_bus.sr2_tag = 3'd0;
        #1;
        checkOutput("lookup_sr1_ready", 32'(rob_bus.sr1_ready), 32'd1);
        checkOutput("lookup_sr1_value", 32'(rob_bus.sr1_value), 32'h1234);
        checkOutput("lookup_sr2_ready", 32'(rob_bus.sr2_ready), 32'd0);
        rob_bus.cdb_valid = 1'b1;
        rob_bus.cdb_tag   = 3'd1;
        rob_bus.cdb_value = 16'hBEEF;
        #1;
`ifdef ROB_BYPASS_EN
        checkOutput("bypass_sr1_value", 32'(rob_bus.sr1_value), 32'hBEEF);
`else
        checkOutput("bypass_sr1_value", 32'(rob_bus.sr1_value), 32'h1234);
`endif
        checkOutput("bypass_sr1_ready", 32'(rob_bus.sr1_ready), 32'd1);
        rob_bus.cdb_tag   = 3'd0;
        rob_bus.cdb_value = 16'h0F0F;
        #1;
`ifdef ROB_BYPASS_EN
        checkOutput("bypass_sr2_ready", 32'(rob_bus.sr2_ready), 32'd1);
        checkOutput("bypass_sr2_value", 32'(rob_bus.sr2_value), 32'h0F0F);
`else
        checkOutput("bypass_sr2_ready", 32'(rob_bus.sr2_ready), 32'd0);
`endif
        rob_bus.cdb_valid = 1'b0;
        applyStimulus(mk(0, op_add, 3'd0, 0, 1, 3'd0, 16'h0F0F, 0, 0, 0, 0, 1, 3'd2), 103);
        checkOutput("lookup_sr2_ready_reg", 32'(rob_bus.sr2_ready), 32'd1);
        checkOutput("lookup_sr2_value_reg", 32'(rob_bus.sr2_value), 32'h0F0F);
        checkOutput("lookup_sr1_value_kept", 32'(rob_bus.sr1_value), 32'h1234);

        // reset asserted mid-cycle with three busy entries and WE high
        applyStimulus(mk(1, op_ldb, 3'd4, 0, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 1, 3'd3), 104);
        rob_bus.WE        = 1'b1;
        rob_bus.opcode_in = op_stb;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_empty", 32'(rob_bus.empty), 32'd1);
        checkOutput("midreset_full", 32'(rob_bus.full), 32'd0);
        checkOutput("midreset_valid_out", 32'(rob_bus.valid_out), 32'd0);
        checkOutput("midreset_alloc_tag", 32'(rob_bus.alloc_tag), 32'd0);
        sb.delete();
        model_tail = 3'd0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        driveIdle();
        #1;
        checkOutput("postreset_alloc_tag", 32'(rob_bus.alloc_tag), 32'd0);
        checkOutput("postreset_empty", 32'(rob_bus.empty), 32'd1);
        applyStimulus(mk(1, op_add, 3'd0, 0, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 0, 3'd1), 105);
        applyStimulus(mk(0, op_add, 3'd0, 0, 1, 3'd0, 16'h5A5A, 0, 0, 0, 0, 1, 3'd1), 106);
        applyStimulus(mk(0, op_add, 3'd0, 0, 0, 3'd0, 16'h0000, 1, 0, 1, 0, 0, 3'd1), 107);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
